// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring RV32M divide/remainder unit.
// One quotient bit per cycle; divide-by-zero and signed overflow finish
// in a single cycle. The result is presented with done and held afterwards.
module div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      op_q;
  logic            sa, sb, raw;
  logic [XLEN-1:0] quo, dvs, rem, result_q, fix;
  logic [CW-1:0]   cnt;

  // operand decode: op[0]=1 means unsigned, op[1]=1 means remainder
  logic            signed_op, a_neg, b_neg, div0, ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] quo_f, rem_f;

  // operand magnitudes and fast-path detection, evaluated while IDLE
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[XLEN-1];
    b_neg     = signed_op & b[XLEN-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    div0      = (b == '0);
    ovf       = signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    fast      = div0 | ovf;
  end

  // one restoring step; the extra top bit makes the borrow exact for
  // divisors at or above 2^(XLEN-1)
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs};
  end

  // sign fixup; fast-path results are preloaded final values and bypass it
  always_comb begin
    quo_f = (!raw && !op_q[0] && (sa ^ sb)) ? -quo : quo;
    rem_f = (!raw && !op_q[0] && sa)        ? -rem : rem;
    fix   = op_q[1] ? rem_f : quo_f;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; flush wins over start
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = fast ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // datapath: operand capture, iteration, and result hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      raw      <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          sa   <= a_neg;
          sb   <= b_neg;
          dvs  <= b_mag;
          cnt  <= CW'(ITER);
          raw  <= fast;
          if (div0) begin
            quo <= '1;
            rem <= a;
          end else if (ovf) begin
            quo <= {1'b1, {(XLEN-1){1'b0}}};
            rem <= '0;
          end else begin
            quo <= a_mag;
            rem <= '0;
          end
        end
        CALC: begin
          if (!diff[XLEN]) begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        DONE: result_q <= fix;
        default: ;
      endcase
    end
  end

  // outputs: result is live during done, then held
  always_comb begin
    busy   = (state == CALC);
    done   = (state == DONE);
    result = done ? fix : result_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit against a plain
// arithmetic reference; expected results queue up at issue time and a
// monitor compares them whenever done is seen.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  div_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] lastres;
  logic [31:0] mon_e;

  // reference model straight from the RV32M rules
  function automatic logic [31:0] ref_model(input logic [1:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'd0: if (y == 0) return 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return 32'(sx / sy);
      2'd1: if (y == 0) return 32'hFFFF_FFFF; else return x / y;
      2'd2: if (y == 0) return x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            else return 32'(sx % sy);
      default: if (y == 0) return x; else return x % y;
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y);
    return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result %h with nothing outstanding", result);
      end else begin
        mon_e = exp_q.pop_front();
        if (result !== mon_e) begin
          errors++;
          $display("FAIL result: got %h expected %h", result, mon_e);
        end
      end
    end
  end

  // issue one op at posedge+1 (cycle 0), hold start until done, check
  // busy per cycle and done latency; optionally scramble inputs mid-CALC
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit scramble);
    int lat, cyc;
    logic [31:0] e;
    e   = ref_model(o, x, y);
    lat = is_fast(o, x, y) ? 1 : 33;
    exp_q.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    cyc = 0;
    forever begin
      @(negedge clk);
      check("busy", {31'd0, busy}, {31'd0, (lat == 33 && cyc >= 1 && cyc <= 32)});
      if (done) begin
        check("done_cycle", cyc, lat);
        lastres = e;
        break;
      end
      if (cyc >= 60) begin
        errors++;
        $display("FAIL timeout: no done after %0d cycles, expected cycle %0d", cyc, lat);
        exp_q.delete();
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (scramble && cyc == 5) begin
        op = 2'($urandom); a = $urandom; b = $urandom;
      end
      if (scramble && cyc == 20) start = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // start DIVU 1000/3, kill it in cycle 10 with flush or rst, then 9/3
  task automatic abort_run(input bit use_rst);
    start = 1'b1; op = 2'd1; a = 32'd1000; b = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    if (use_rst) lastres = 32'd0;
    @(negedge clk);
    check(use_rst ? "rst_busy" : "flush_busy", {31'd0, busy}, 32'd0);
    check(use_rst ? "rst_done" : "flush_done", {31'd0, done}, 32'd0);
    check(use_rst ? "rst_result" : "flush_result", result, lastres);
    @(posedge clk); #1;
    run_op(2'd1, 32'd9, 32'd3, 1'b0);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;
    int          sel;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    lastres = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); #1;

    // DIVU 100/7 and result hold
    run_op(2'd1, 32'd100, 32'd7, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    check("hold_result", result, 32'd14);
    @(posedge clk); #1;

    // signed and boundary cases
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(2'd1, 32'd5, 32'd0, 1'b0);
    run_op(2'd3, 32'd5, 32'd0, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // abort paths
    abort_run(1'b0);
    abort_run(1'b1);

    // back-to-back with mid-CALC input changes
    run_op(2'd0, 32'd20, 32'hFFFF_FFFC, 1'b0);
    run_op(2'd3, 32'd17, 32'd5, 1'b1);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      o   = 2'($urandom);
      sel = $urandom_range(0, 9);
      x   = $urandom;
      case (sel)
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: y = $urandom >> $urandom_range(0, 31);
        4: y = 32'h8000_0000 | $urandom;
        default: y = $urandom;
      endcase
      if (y == 0 && sel != 0) y = 32'd1;
      run_op(o, x, y, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divide/remainder unit in the execute stage. It sits beside the ALU on the same forwarded operand buses a/b.
- Its result is muxed with the ALU result into the EX/MEM register.
- The hazard unit stalls IF/ID/EX while a divide instruction is in EX and the unit has not yet pulsed done.
- Iterative radix-2 restoring divider: one quotient bit per cycle, with fast paths for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count; must equal XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  divide op valid in EX; held high by the pipeline until done.
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  input  XLEN  dividend (rs1, forwarded).
- b  input  XLEN  divisor (rs2, forwarded).
- flush  input  1  synchronous kill of the in-flight op (branch/trap flush of EX).
- busy  output  1  high while iterating (state CALC).
- done  output  1  one-cycle pulse; result valid in the same cycle.
- result  output  XLEN  quotient or remainder; holds its value until the next done.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, busy=0, done=0, result=0, internal regs cleared. rst has priority over everything, including mid-operation.
- flush=1 at an edge: state goes to IDLE. No done is produced and result is unchanged. flush has priority over start in the same cycle.
- States and transitions:
  - IDLE: if start=1, latch op, the a/b signs, and |a|, |b|. Magnitudes are taken only for signed ops (DIV, REM); unsigned ops use raw values.
  - IDLE, fast path: if b==0, or signed op with a==0x80000000 and b==0xFFFFFFFF, go to DONE directly. Otherwise clear the remainder register, load the iteration counter with ITER, and go to CALC.
  - CALC: each cycle, shift {rem,quo} left by 1 and trial-subtract the divisor from rem. If the result is non-negative, keep it and set quo LSB=1, else restore. Decrement the counter; after the 32nd iteration go to DONE.
  - DONE: done=1 for exactly one cycle. result is driven from a combinational sign-fixup of the final quo/rem, registered into result at the DONE edge so it holds afterwards. Next state is always IDLE; start is ignored in DONE.
- Sign fixup:
  - DIV quotient is negated if sign(a)!=sign(b).
  - REM remainder takes the sign of the dividend (negate if a<0).
- Special results:
  - Divide-by-zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Overflow (DIV 0x80000000 / -1): quotient 0x80000000, remainder 0.
- Latency, with start first high in cycle 0 while IDLE:
  - Normal ops: CALC occupies cycles 1..32, done in cycle 33.
  - Fast-path ops: done in cycle 1.
- busy is low in IDLE and DONE. The hazard unit stall condition is start && !done.
- Operand capture:
  - Operands are sampled only on the IDLE->CALC/DONE transition.
  - Later changes on a/b/op while in CALC are ignored.
  - start dropping while in CALC does not abort; only flush/rst abort.
- Back-to-back: after DONE the unit is in IDLE, so a new start in the cycle following done is accepted with no gap beyond that cycle.
- Arithmetic: the remainder datapath is XLEN+1 bits wide so the trial subtraction sign is exact for unsigned operands ≥ 2^31.

Test Plan:
- DIVU a=100, b=7, start held from cycle 0 -> busy 1 in cycles 1..32; done=1 only in cycle 33 with result=14; result still 14 in cycle 40.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). REMU a=0xFFFFFFFF, b=0x80000000 -> 0x7FFFFFFF.
- DIVU a=5, b=0 -> done in cycle 1, result 0xFFFFFFFF; REMU a=5, b=0 -> 5; busy never asserted.
- DIV a=0x80000000, b=0xFFFFFFFF -> done in cycle 1, result 0x80000000; REM same operands -> 0.
- Flush and reset abort:
  - DIVU 1000/3 started in cycle 0, flush=1 in cycle 10 -> busy 0 in cycle 11, no done, result keeps its prior value.
  - Then DIVU 9/3 started in cycle 12 -> done in cycle 45 with result 3.
  - Repeat with rst in cycle 10 instead of flush -> result 0.
- Back-to-back: DIV 20/-4 then, in the cycle after its done, REMU 17/5 with a/b/op changed mid-CALC -> results 0xFFFFFFFB then 2; mid-CALC changes are ignored.
